// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection and forwarding control for an in-order
// pipeline. Tracks the instructions in the stages after ID, and drives the
// stall, flush, bubble and freeze controls and the EX operand-forwarding selects.
// Optional feature: define HAZ_PERF_CNT_EN to add saturating stall/flush counters.
//
// Memory handshake: while the MEM-stage entry holds a load or store,
// mem_ready_i=1 means the access completes in this cycle. mem_ready_i=0 means
// the access is still pending, and the whole pipeline holds until a cycle
// samples mem_ready_i=1. mem_ready_i is ignored when the MEM-stage entry does
// not access memory.
module pipe_hazard_ctrl #(
    parameter int RA_W      = 5,
    parameter int FWD_DEPTH = 3,
    localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             id_valid_i,
    input  logic [RA_W-1:0]  id_rs_i,
    input  logic [RA_W-1:0]  id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic [RA_W-1:0]  id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             id_memwrite_i,
    input  logic             branch_taken_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic [SEL_W-1:0] fwd_rs_o,
    output logic [SEL_W-1:0] fwd_rt_o,
    output logic [1:0]       dbg_state_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt_o,
    output logic [15:0]      flush_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FREEZE = 2'd2;

    // One tracked instruction; entry 1 is EX, entry 2 is MEM, and so on.
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic            uses_rt;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            memread;
        logic            memop;
    } trk_t;

    trk_t       trk [1:FWD_DEPTH];
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       running;
    logic       freeze_cond;
    logic       load_use;
    logic       branch_flush;

    assign dbg_state_o = state;
    assign running     = (state == ST_RUN) || (state == ST_FREEZE);

    // Raw hazard conditions from the tracker and the ID-stage fields.
    always_comb begin
        freeze_cond  = trk[2].valid && trk[2].memop && !mem_ready_i;
        load_use     = id_valid_i && trk[1].valid && trk[1].memread &&
                       (trk[1].rd != '0) &&
                       ((trk[1].rd == id_rs_i) ||
                        (id_uses_rt_i && (trk[1].rd == id_rt_i)));
        branch_flush = branch_taken_i && trk[1].valid;
    end

    // Prioritised pipeline controls: idle > freeze > branch flush > load-use > normal.
    // The FREEZE state uses the same freeze condition as RUN, so the cycle that
    // samples mem_ready_i=1 is already a normal, advancing cycle.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b0;
        if (!running) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            pipe_freeze_o = 1'b1;
        end else if (freeze_cond) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            pipe_freeze_o = 1'b1;
        end else if (branch_flush) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

    // Run-control FSM next-state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_i) state_nxt = ST_RUN;
            ST_RUN: begin
                if (!start_i)         state_nxt = ST_IDLE;
                else if (freeze_cond) state_nxt = ST_FREEZE;
            end
            ST_FREEZE: if (mem_ready_i) state_nxt = ST_RUN;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Tracker shift: entry 1 takes the ID instruction (or a bubble), the rest
    // move one stage down, the last one retires. Holds whenever frozen or idle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 1; k <= FWD_DEPTH; k++) trk[k] <= '0;
        end else if (!pipe_freeze_o) begin
            trk[1].valid    <= id_valid_i && !idex_bubble_o;
            trk[1].rs       <= id_rs_i;
            trk[1].rt       <= id_rt_i;
            trk[1].uses_rt  <= id_uses_rt_i;
            trk[1].rd       <= id_rd_i;
            trk[1].regwrite <= id_regwrite_i;
            trk[1].memread  <= id_memread_i;
            trk[1].memop    <= id_memread_i || id_memwrite_i;
            for (int k = 2; k <= FWD_DEPTH; k++) trk[k] <= trk[k-1];
        end
    end

    // Forwarding selects: scanning from the oldest entry down so the nearest
    // (smallest k) producer wins. Register 0 and invalid entries never forward.
    always_comb begin
        fwd_rs_o = '0;
        fwd_rt_o = '0;
        for (int k = FWD_DEPTH; k >= 2; k--) begin
            if (trk[1].valid && trk[k].valid && trk[k].regwrite && (trk[k].rd != '0)) begin
                if (trk[k].rd == trk[1].rs) fwd_rs_o = SEL_W'(k);
                if (trk[1].uses_rt && (trk[k].rd == trk[1].rt)) fwd_rt_o = SEL_W'(k);
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating counters of stalled (PC held) cycles and IF/ID flushes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (running && !pc_write_o && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (ifid_flush_o && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (RA_W=5, FWD_DEPTH=3).
// Each step drives ID inputs just after a rising edge, lets them settle,
// checks outputs mid-cycle, then advances one clock. Tracker contents after
// each edge are noted as [EX, MEM, WB].
module tb_pipe_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       id_valid_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       id_uses_rt_i;
    logic [4:0] id_rd_i;
    logic       id_regwrite_i;
    logic       id_memread_i;
    logic       id_memwrite_i;
    logic       branch_taken_i;
    logic       mem_ready_i;
    logic       pc_write_o;
    logic       ifid_write_o;
    logic       ifid_flush_o;
    logic       idex_bubble_o;
    logic       pipe_freeze_o;
    logic [1:0] fwd_rs_o;
    logic [1:0] fwd_rt_o;
    logic [1:0] dbg_state_o;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
`endif

    // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
    logic [4:0] ctl;
    assign ctl = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.RA_W(5), .FWD_DEPTH(3)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_uses_rt_i   (id_uses_rt_i),
        .id_rd_i        (id_rd_i),
        .id_regwrite_i  (id_regwrite_i),
        .id_memread_i   (id_memread_i),
        .id_memwrite_i  (id_memwrite_i),
        .branch_taken_i (branch_taken_i),
        .mem_ready_i    (mem_ready_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .pipe_freeze_o  (pipe_freeze_o),
        .fwd_rs_o       (fwd_rs_o),
        .fwd_rt_o       (fwd_rt_o),
        .dbg_state_o    (dbg_state_o)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
`endif
    );

    // Clock generation.
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [4:0] exp_v);
        chk(tag, 32'(ctl), 32'(exp_v));
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] exp_rs, input logic [1:0] exp_rt);
        chk({tag, "_rs"}, 32'(fwd_rs_o), 32'(exp_rs));
        chk({tag, "_rt"}, 32'(fwd_rt_o), 32'(exp_rt));
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp_v);
        chk(tag, 32'(dbg_state_o), 32'(exp_v));
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urt, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic mw);
        id_valid_i    = v;
        id_rs_i       = rs;
        id_rt_i       = rt;
        id_uses_rt_i  = urt;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
        id_memwrite_i = mw;
    endtask

    task automatic id_idle();
        id_set(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_i = 1'b0;
        start_i = 1'b0;
        branch_taken_i = 1'b0;
        mem_ready_i = 1'b1;
        id_idle();
        cycle();
        chk_ctl("rst_ctl", 5'b00001);
        chk_fwd("rst_fwd", 2'd0, 2'd0);
        chk_state("rst_state", 2'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("rst_stall_cnt", stall_cnt_o, 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b1;
        start_i = 1'b1;
        cycle();                                   // IDLE -> RUN
        chk_state("run_state", 2'd1);

        // ---------------- memory wait on a store ----------------
        id_set(1, 5'd1, 5'd1, 0, 5'd2, 1, 0, 0);   // W: writes r2
        #1 chk_ctl("run_normal", 5'b11000);
        cycle();                                   // [W2, -, -]
        id_set(1, 5'd1, 5'd9, 1, 5'd0, 0, 0, 1);   // store
        cycle();                                   // [sw, W2, -]
        id_set(1, 5'd2, 5'd3, 1, 5'd4, 1, 0, 0);   // I: reads r2, writes r4
        cycle();                                   // [I, sw, W2]
        id_set(1, 5'd4, 5'd4, 1, 5'd6, 1, 0, 0);   // J: reads r4
        mem_ready_i = 1'b0;
        #1 chk_ctl("mw_c1", 5'b00001);
        chk_fwd("mw_c1", 2'd3, 2'd0);
        chk_state("mw_c1_state", 2'd1);
        cycle();
        #1 chk_ctl("mw_c2", 5'b00001);
        chk_fwd("mw_c2", 2'd3, 2'd0);
        chk_state("mw_c2_state", 2'd2);
        cycle();
        #1 chk_ctl("mw_c3", 5'b00001);
        chk_fwd("mw_c3", 2'd3, 2'd0);
        cycle();
        mem_ready_i = 1'b1;
        #1 chk_ctl("mw_release", 5'b11000);
        chk_fwd("mw_release", 2'd3, 2'd0);
        chk_state("mw_release_state", 2'd2);
`ifdef HAZ_PERF_CNT_EN
        chk("mw_stall_cnt", stall_cnt_o, 32'd3);
`endif
        cycle();                                   // [J, I, sw]
        id_idle();
        #1 chk_fwd("fwd_e2", 2'd2, 2'd2);
        chk_state("mw_after_state", 2'd1);
        cycle();                                   // [-, J, I]

        // ---------------- load-use ----------------
        id_set(1, 5'd1, 5'd8, 0, 5'd8, 1, 1, 0);   // lw r8
        cycle();                                   // [lw8, -, J]
        id_set(1, 5'd8, 5'd2, 1, 5'd9, 1, 0, 0);   // add r9 = r8 + r2
        #1 chk_ctl("lu_stall", 5'b00010);
        cycle();                                   // [bub, lw8, -]
        #1 chk_ctl("lu_once", 5'b11000);
        cycle();                                   // [add, bub, lw8]
        id_idle();
        // After the bubble the load sits in the WB entry when add reaches EX.
        #1 chk_fwd("lu_fwd", 2'd3, 2'd0);
        cycle();                                   // [-, add, bub]

        // ---------------- nearest producer wins ----------------
        id_set(1, 5'd1, 5'd2, 1, 5'd5, 1, 0, 0);   // A: writes r5
        cycle();                                   // [A5, -, add]
        id_set(1, 5'd3, 5'd4, 1, 5'd5, 1, 0, 0);   // B: writes r5
        cycle();                                   // [B5, A5, -]
        id_set(1, 5'd5, 5'd6, 1, 5'd7, 1, 0, 0);   // C: reads r5
        #1 chk_fwd("no_match", 2'd0, 2'd0);
        cycle();                                   // [C, B5, A5]
        id_set(1, 5'd5, 5'd5, 1, 5'd10, 1, 0, 0);  // E: reads r5 twice
        #1 chk_fwd("fwd_nearest", 2'd2, 2'd0);
        cycle();                                   // [E, C(r7), B5]
        id_idle();
        #1 chk_fwd("fwd_far", 2'd3, 2'd3);
        cycle();                                   // [-, E, C]

        // ---------------- register 0 / unused rt ----------------
        id_set(1, 5'd1, 5'd2, 1, 5'd0, 1, 0, 0);   // Z: writes r0
        cycle();                                   // [Z0, -, E]
        id_set(1, 5'd0, 5'd0, 0, 5'd11, 1, 0, 0);  // F: rs=r0, rt=r0 unused
        cycle();                                   // [F, Z0, -]
        id_set(1, 5'd12, 5'd11, 0, 5'd13, 1, 0, 0); // G: rt=r11 unused
        #1 chk_fwd("r0", 2'd0, 2'd0);
        cycle();                                   // [G, F11, Z0]
        id_idle();
        #1 chk_fwd("rt_unused", 2'd0, 2'd0);
        cycle();                                   // [-, G, F]

        // ---------------- branch overrides load-use ----------------
        id_set(1, 5'd1, 5'd8, 0, 5'd8, 1, 1, 0);   // lw r8
        cycle();                                   // [lw8, -, G]
        id_set(1, 5'd8, 5'd3, 1, 5'd9, 1, 0, 0);
        branch_taken_i = 1'b1;
        #1 chk_ctl("br_over_lu", 5'b11110);
        cycle();                                   // [bub, lw8, -]
        id_idle();
        #1 chk_ctl("br_no_ex", 5'b11000);          // branch ignored, EX empty
        branch_taken_i = 1'b0;
`ifdef HAZ_PERF_CNT_EN
        chk("br_flush_cnt", 32'(flush_cnt_o), 32'd1);
        chk("br_stall_cnt", stall_cnt_o, 32'd4);
`endif
        // ---------------- start low returns to IDLE ----------------
        start_i = 1'b0;
        cycle();
        #1 chk_ctl("idle_ctl", 5'b00001);
        chk_state("idle_state", 2'd0);
        start_i = 1'b1;
        cycle();
        chk_state("rerun_state", 2'd1);

        // ---------------- reset during FREEZE ----------------
        id_set(1, 5'd1, 5'd2, 1, 5'd0, 0, 0, 1);   // store
        cycle();                                   // [sw, -, -]
        id_idle();
        cycle();                                   // [-, sw, -]
        mem_ready_i = 1'b0;
        #1 chk_ctl("f_freeze", 5'b00001);
        cycle();
        chk_state("f_state", 2'd2);
        rst_i = 1'b0;
        #1 chk_ctl("frz_rst_ctl", 5'b00001);
        chk_fwd("frz_rst_fwd", 2'd0, 2'd0);
        chk_state("frz_rst_state", 2'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("frz_rst_stall_cnt", stall_cnt_o, 32'd0);
        chk("frz_rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b1;                              // mem_ready_i still low
        cycle();
        #1 chk_ctl("post_rst", 5'b11000);
        chk_state("post_rst_state", 2'd1);
        cycle();
        #1 chk_ctl("no_residual", 5'b11000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
